// File: rtl/pacman_soc_usb_rst_seq_pkg.sv
// Shared encodings for the CY7C67200 reset sequencer.
// Covers FSM states, Avalon register offsets and STATUS/CTRL bit positions.
package pacman_usb_rst_pkg;

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_RECOVER = 2'd1,
    ST_READY   = 2'd2
  } rst_state_e;

  localparam logic [1:0] REG_STATUS = 2'd0;
  localparam logic [1:0] REG_CTRL   = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;

  localparam int STAT_OTG_BIT   = 0;
  localparam int STAT_READY_BIT = 1;
  localparam int STAT_IRQ_BIT   = 2;
  localparam int STAT_STATE_LSB = 3;

  localparam int CTRL_PULSE_BIT  = 0;
  localparam int CTRL_IRQCLR_BIT = 1;

  function automatic logic [31:0] status_word(logic otg, logic rdy, logic irq, rst_state_e st);
    logic [31:0] w;
    w = '0;
    w[STAT_OTG_BIT]   = otg;
    w[STAT_READY_BIT] = rdy;
    w[STAT_IRQ_BIT]   = irq;
    w[STAT_STATE_LSB +: 2] = st;
    return w;
  endfunction

endpackage

// File: rtl/pacman_soc_usb_rst_seq_if.sv
// Avalon-MM slave bundle for the reset sequencer register window.
interface pacman_soc_usb_rst_seq_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/pacman_soc_usb_rst_seq_sync.sv
// Two-flop synchroniser for a single level crossing into the clk domain.
module pacman_sync_bit (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);
  logic [1:0] ff_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ff_q <= '0;
    else          ff_q <= {ff_q[0], d};
  end

  assign q = ff_q[1];
endmodule

// File: rtl/pacman_soc_usb_rst_seq.sv
// Timed reset sequencer for the CY7C67200 OTG chip: min low width, recovery wait,
// readiness status and sticky done IRQ over a small Avalon-MM slave.
import pacman_usb_rst_pkg::*;

module pacman_soc_usb_rst_seq #(
  parameter int ASSERT_CYCLES  = 500000,
  parameter int RECOVER_CYCLES = 250000,
  parameter int CNT_W          = 24
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     rst_req,
  pacman_soc_usb_rst_seq_if.slave  avs,
  output logic                     otg_rst_n,
  output logic                     ready,
  output logic                     irq
);
  localparam logic [CNT_W-1:0] A_MAX = CNT_W'(ASSERT_CYCLES - 1);
  localparam logic [CNT_W-1:0] R_MAX = CNT_W'(RECOVER_CYCLES - 1);

  rst_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             otg_q, ready_q, irq_q;
  logic             req_s;
  logic             wr, pulse_cmd, irq_clr;
  logic [31:0]      rdata_d;
  logic             unused_wdata;

  pacman_sync_bit u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (rst_req),
    .q       (req_s)
  );

  assign wr        = avs.chipselect & ~avs.write_n;
  assign pulse_cmd = wr & (avs.address == REG_CTRL) & avs.writedata[CTRL_PULSE_BIT];
  assign irq_clr   = wr & (avs.address == REG_CTRL) & avs.writedata[CTRL_IRQCLR_BIT];
  assign unused_wdata = ^avs.writedata[31:2];

  // Outputs are loaded on the same edge as the state so they always mirror state_q.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_ASSERT;
      cnt_q   <= '0;
      otg_q   <= 1'b0;
      ready_q <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      if (irq_clr) irq_q <= 1'b0;
      case (state_q)
        ST_ASSERT: begin
          if (pulse_cmd)            cnt_q <= '0;
          else if (cnt_q != A_MAX)  cnt_q <= cnt_q + CNT_W'(1);
          else if (!req_s) begin
            state_q <= ST_RECOVER;
            cnt_q   <= '0;
            otg_q   <= 1'b1;
          end
        end
        ST_RECOVER: begin
          if (req_s || pulse_cmd) begin
            state_q <= ST_ASSERT;
            cnt_q   <= '0;
            otg_q   <= 1'b0;
          end else if (cnt_q == R_MAX) begin
            state_q <= ST_READY;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            irq_q   <= 1'b1;   // overrides a same-cycle clear
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_READY: begin
          cnt_q <= '0;
          if (req_s || pulse_cmd) begin
            state_q <= ST_ASSERT;
            otg_q   <= 1'b0;
            ready_q <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_ASSERT;
          cnt_q   <= '0;
          otg_q   <= 1'b0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    rdata_d = '0;
    case (avs.address)
      REG_STATUS: rdata_d = status_word(otg_q, ready_q, irq_q, state_q);
      REG_COUNT:  rdata_d = 32'(cnt_q);
      default:    rdata_d = '0;
    endcase
  end

  assign avs.readdata = rdata_d;
  assign otg_rst_n    = otg_q;
  assign ready        = ready_q;
  assign irq          = irq_q;
endmodule

// File: tb/tb_pacman_soc_usb_rst_seq.sv
// Directed bench for the OTG reset sequencer with ASSERT_CYCLES=8, RECOVER_CYCLES=4.
module tb_pacman_soc_usb_rst_seq;
  logic clk, reset_n, rst_req;
  logic otg_rst_n, ready, irq;
  int   ntest, nfail;

  pacman_soc_usb_rst_seq_if bus ();

  pacman_soc_usb_rst_seq #(.ASSERT_CYCLES(8), .RECOVER_CYCLES(4), .CNT_W(24)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .rst_req   (rst_req),
    .avs       (bus),
    .otg_rst_n (otg_rst_n),
    .ready     (ready),
    .irq       (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntest++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.address = a; bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.writedata = d;
    tick();
    bus.address = 2'd0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    bus.address = a;
    #1 d = bus.readdata;
    bus.address = 2'd0;
  endtask

  // Samples (current included) during which otg_rst_n stays low; bounded.
  task automatic low_len(output int n);
    n = 0;
    while (otg_rst_n === 1'b0 && n < 60) begin n++; tick(); end
  endtask

  task automatic wait_otg(input logic v, output int n);
    n = 0;
    while (otg_rst_n !== v && n < 60) begin tick(); n++; end
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (ready !== 1'b1 && n < 60) begin tick(); n++; end
  endtask

  initial begin
    logic [31:0] d;
    int n, hi;
    ntest = 0; nfail = 0;
    reset_n = 1'b0; rst_req = 1'b0;
    bus.address = 2'd0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;
    @(negedge clk); @(negedge clk);

    // reset state
    chk("rst_otg", 32'(otg_rst_n), 0);
    chk("rst_ready", 32'(ready), 0);
    chk("rst_irq", 32'(irq), 0);
    rd(2'd0, d); chk("rst_status", d, 32'h00);
    rd(2'd2, d); chk("rst_count", d, 0);

    // 1: power-up sequence
    reset_n = 1'b1;
    low_len(n);    chk("t1_low_len", n, 8);
    rd(2'd0, d);   chk("t1_status_recover", d, 32'h09);
    wait_ready(n); chk("t1_recover_len", n, 4);
    chk("t1_irq", 32'(irq), 1);
    rd(2'd0, d);   chk("t1_status_ready", d, 32'h17);
    rd(2'd2, d);   chk("t1_count_ready", d, 0);

    // 2: rst_req held high 30 cycles
    rst_req = 1'b1;
    wait_otg(1'b0, n); chk("t2_rise_lat", n, 3);
    hi = 0;
    repeat (27) begin tick(); if (otg_rst_n !== 1'b0) hi++; end
    chk("t2_held_low", hi, 0);
    rd(2'd2, d); chk("t2_count_sat", d, 7);
    rst_req = 1'b0;
    wait_otg(1'b1, n); chk("t2_fall_lat", n, 3);
    chk("t2_low_ge8", 32'((1 + 27 + n - 1) >= 8), 1);
    wait_ready(n); chk("t2_recover_len", n, 4);

    // 1-cycle glitch in READY still gives a full sequence
    rst_req = 1'b1; tick(); rst_req = 1'b0;
    wait_otg(1'b0, n); chk("glitch_lat", n, 2);
    low_len(n);        chk("glitch_low_len", n, 8);
    wait_ready(n);     chk("glitch_recover_len", n, 4);

    // 3: software pulse, then restart at cnt=5
    wr(2'd1, 32'h1);
    low_len(n);    chk("t3_low_len", n, 8);
    wait_ready(n); chk("t3_recover_len", n, 4);
    wr(2'd1, 32'h1);
    repeat (5) tick();
    rd(2'd2, d);   chk("t3_count5", d, 5);
    wr(2'd1, 32'h1);
    rd(2'd2, d);   chk("t3_count_restart", d, 0);
    low_len(n);    chk("t3_total_low", 6 + n, 14);
    wait_ready(n); chk("t3b_recover_len", n, 4);

    // 4: abort in RECOVER at cnt=2
    wr(2'd1, 32'h2);
    chk("t4_irq_cleared", 32'(irq), 0);
    chk("t4_ready_kept", 32'(ready), 1);
    wr(2'd1, 32'h1);
    low_len(n);    chk("t4_low_len", n, 8);
    tick(); tick();
    rd(2'd2, d);   chk("t4_count2", d, 2);
    rd(2'd0, d);   chk("t4_status_recover", d, 32'h09);
    wr(2'd1, 32'h1);
    rd(2'd0, d);   chk("t4_status_abort", d, 32'h00);
    rd(2'd2, d);   chk("t4_count_abort", d, 0);

    // 5: clear coincident with RECOVER->READY, set wins
    low_len(n);    chk("t5_low_len", n, 8);
    repeat (3) tick();
    rd(2'd2, d);   chk("t5_count3", d, 3);
    wr(2'd1, 32'h2);
    rd(2'd0, d);   chk("t5_set_wins", d, 32'h17);
    wr(2'd1, 32'h2);
    rd(2'd0, d);   chk("t5_irq_clear", d, 32'h13);
    rd(2'd1, d);   chk("t5_ctrl_reads0", d, 0);
    wr(2'd3, 32'h3);
    rd(2'd0, d);   chk("t5_addr3_ignored", d, 32'h13);
    rd(2'd3, d);   chk("t5_addr3_reads0", d, 0);

    // 6: async reset mid-RECOVER with irq pending
    wr(2'd1, 32'h1);
    low_len(n);    chk("t6_low_len", n, 8);
    wait_ready(n); chk("t6_recover_len", n, 4);
    wr(2'd1, 32'h1);
    low_len(n);
    tick();
    rd(2'd0, d);   chk("t6_status_pre", d, 32'h0D);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_otg", 32'(otg_rst_n), 0);
    chk("t6_ready", 32'(ready), 0);
    chk("t6_irq", 32'(irq), 0);
    rd(2'd0, d);   chk("t6_status", d, 32'h00);
    rd(2'd2, d);   chk("t6_count", d, 0);
    @(negedge clk);
    reset_n = 1'b1;
    low_len(n);    chk("t6_rerun_low", n, 8);

    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end
endmodule
